// File: rtl/ps2_key_cmd_ctrl.sv
// PS/2 scan-code sequencer: tracks E0/F0 prefixes, decodes key releases into
// 4-bit commands and queues them in a FWFT FIFO. Optional prefix timeout: KBD_PREFIX_TIMEOUT_EN.
module ps2_key_cmd_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_data,
  output logic                     rx_en,
  output logic                     cmd_valid,
  output logic [3:0]               cmd_code,
  input  logic                     cmd_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("ps2_key_cmd_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;

  state_t     state;
  logic       ext;
  logic       is_e0, is_f0;
  logic [3:0] dec_code;
  logic       push, wr, pop, full;

  assign is_e0 = (rx_data == 8'hE0);
  assign is_f0 = (rx_data == 8'hF0);

  // Arrows decode regardless of E0; letters and ESC only without it.
  always_comb begin
    dec_code = 4'd0;
    case (rx_data)
      8'h75:   dec_code = 4'd4;
      8'h74:   dec_code = 4'd5;
      8'h6B:   dec_code = 4'd6;
      8'h72:   dec_code = 4'd7;
      8'h2B:   if (!ext) dec_code = 4'd1;
      8'h33:   if (!ext) dec_code = 4'd2;
      8'h2C:   if (!ext) dec_code = 4'd3;
      8'h76:   if (!ext) dec_code = 4'd8;
      default: dec_code = 4'd0;
    endcase
  end

  assign push = rx_done_tick && (state == BRK) && !is_e0 && !is_f0 && (dec_code != 4'd0);

`ifdef KBD_PREFIX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] to_cnt;
  logic          expired;
  assign expired = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ext   <= 1'b0;
`ifdef KBD_PREFIX_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else if (rx_done_tick) begin
`ifdef KBD_PREFIX_TIMEOUT_EN
      to_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (is_e0) begin
            state <= EXT;
            ext   <= 1'b1;
          end else if (is_f0) begin
            state <= BRK;
            ext   <= 1'b0;
          end
        end
        EXT: begin
          if (is_f0)      state <= BRK;
          else if (is_e0) state <= EXT;
          else begin
            state <= IDLE;
            ext   <= 1'b0;
          end
        end
        BRK: begin
          if (is_f0) state <= BRK;
          else if (is_e0) begin
            state <= EXT;
            ext   <= 1'b1;
          end else begin
            state <= IDLE;
            ext   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ext   <= 1'b0;
        end
      endcase
    end
`ifdef KBD_PREFIX_TIMEOUT_EN
    else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (expired) begin
      state  <= IDLE;
      ext    <= 1'b0;
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
`endif
  end

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign full      = (fifo_level == (AW + 1)'(DEPTH));
  assign cmd_valid = (fifo_level != '0);
  assign rx_en     = ~full;
  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr        = push & (~full | pop);
  assign cmd_code  = cmd_valid ? mem[rd_ptr] : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (push && !wr) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= dec_code;
  end

endmodule
